// File: rtl/mem_arbiter_if.sv
// Request/response and byte-wide memory bus bundle for mem_arbiter.
// The slave modport is the arbiter side; the master modport is the requester/memory side.
interface mem_arbiter_if #(
    parameter int NUM_CH     = 2,
    parameter int DATA_BYTES = 16
) ();
    localparam int LW = $clog2(DATA_BYTES) + 1;

    logic [NUM_CH-1:0]              reqValid;
    logic [NUM_CH-1:0]              reqWrite;
    logic [NUM_CH*32-1:0]           reqAddr;
    logic [NUM_CH*LW-1:0]           reqLen;
    logic [NUM_CH*DATA_BYTES*8-1:0] reqData;
    logic [NUM_CH-1:0]              respValid;
    logic [DATA_BYTES*8-1:0]        respData;
    logic [7:0]                     memIn;
    logic [7:0]                     memOut;
    logic [31:0]                    memAddr;
    logic                           readWriteOut;
    logic                           ioBufferFull;
    logic                           busy;

    modport slave (
        input  reqValid, reqWrite, reqAddr, reqLen, reqData, memIn, ioBufferFull,
        output respValid, respData, memOut, memAddr, readWriteOut, busy
    );

    modport master (
        output reqValid, reqWrite, reqAddr, reqLen, reqData, memIn, ioBufferFull,
        input  respValid, respData, memOut, memAddr, readWriteOut, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Multi-channel arbiter onto a byte-serial memory bus: N-byte read takes N+1 cycles, write N cycles, then one RESP cycle.
// readyIn low freezes everything (unsampled read byte re-issued on resume); IO-region writes stall while ioBufferFull.
module mem_arbiter #(
    parameter int                NUM_CH     = 2,
    parameter int                DATA_BYTES = 16,
    parameter int                ARB_MODE   = 0,
    parameter logic [NUM_CH-1:0] CLEAR_MASK = '1
) (
    input  logic         clockIn,
    input  logic         resetIn,
    input  logic         readyIn,
    input  logic         clearIn,
    mem_arbiter_if.slave bus
);
    localparam int              LW       = $clog2(DATA_BYTES) + 1;
    localparam int              CW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int              DW       = DATA_BYTES * 8;
    localparam logic [LW-1:0]   CNT_ONE  = LW'(1);
    localparam logic [CW-1:0]   CH_LAST  = CW'(NUM_CH - 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t            state;
    logic [CW-1:0]     ptr;
    logic [CW-1:0]     grantCh;
    logic [CW-1:0]     pickCh;
    logic              pickVld;
    logic [NUM_CH-1:0] eligible;
    logic [31:0]       addr;
    logic [31:0]       curAddr;
    logic [LW-1:0]     len;
    logic [LW-1:0]     issueCnt;
    logic [LW-1:0]     recvCnt;
    logic              pend;
    logic [DW-1:0]     wrData;
    logic [DW-1:0]     wrShift;
    logic [DW-1:0]     rdBuf;
    logic [DW-1:0]     rdMerged;
    logic [DW-1:0]     respDataQ;
    logic [NUM_CH-1:0] respValidQ;
    logic              ioStall;
    logic              rdIssue;
    logic              wrIssue;

    // A flush suppresses this cycle's grant only for maskable reads; others still compete.
    assign eligible = bus.reqValid & ~({NUM_CH{clearIn}} & ~bus.reqWrite & CLEAR_MASK);

    always_comb begin
        int idx;
        idx     = 0;
        pickVld = 1'b0;
        pickCh  = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = (ARB_MODE == 1) ? k : (int'(ptr) + k) % NUM_CH;
            if (eligible[idx]) begin
                pickVld = 1'b1;
                pickCh  = CW'(idx);
            end
        end
    end

    assign curAddr  = addr + {{(32-LW){1'b0}}, issueCnt};
    assign ioStall  = (curAddr[17:16] == 2'b11) && bus.ioBufferFull;
    assign rdIssue  = (state == READ) && readyIn && (issueCnt < len);
    assign wrIssue  = (state == WRITE) && readyIn && !ioStall;
    assign wrShift  = wrData >> {issueCnt, 3'b000};
    assign rdMerged = rdBuf | ({{(DW-8){1'b0}}, bus.memIn} << {recvCnt, 3'b000});

    assign bus.memAddr      = (rdIssue || wrIssue) ? curAddr : 32'h0;
    assign bus.memOut       = wrIssue ? wrShift[7:0] : 8'h00;
    assign bus.readWriteOut = wrIssue;
    assign bus.busy         = (state != IDLE);
    assign bus.respValid    = respValidQ;
    assign bus.respData     = respDataQ;

    always_ff @(posedge clockIn or posedge resetIn) begin
        if (resetIn) begin
            state      <= IDLE;
            ptr        <= '0;
            grantCh    <= '0;
            addr       <= '0;
            len        <= '0;
            issueCnt   <= '0;
            recvCnt    <= '0;
            pend       <= 1'b0;
            wrData     <= '0;
            rdBuf      <= '0;
            respDataQ  <= '0;
            respValidQ <= '0;
        end else begin
            respValidQ <= '0;
            if (readyIn) begin
                case (state)
                    IDLE: begin
                        if (pickVld) begin
                            grantCh  <= pickCh;
                            addr     <= bus.reqAddr[32*pickCh +: 32];
                            len      <= bus.reqLen[LW*pickCh +: LW];
                            wrData   <= bus.reqData[DW*pickCh +: DW];
                            issueCnt <= '0;
                            recvCnt  <= '0;
                            pend     <= 1'b0;
                            rdBuf    <= '0;
                            state    <= bus.reqWrite[pickCh] ? WRITE : READ;
                            if (ARB_MODE == 0) begin
                                ptr <= (pickCh == CH_LAST) ? '0 : pickCh + CW'(1);
                            end
                        end
                    end
                    READ: begin
                        if (clearIn && CLEAR_MASK[grantCh]) begin
                            state <= IDLE;
                        end else begin
                            if (rdIssue) begin
                                issueCnt <= issueCnt + CNT_ONE;
                            end
                            pend <= rdIssue;
                            // memIn carries the byte issued on the previous cycle.
                            if (pend) begin
                                rdBuf   <= rdMerged;
                                recvCnt <= recvCnt + CNT_ONE;
                                if (recvCnt + CNT_ONE == len) begin
                                    state               <= RESP;
                                    respDataQ           <= rdMerged;
                                    respValidQ[grantCh] <= 1'b1;
                                end
                            end
                        end
                    end
                    WRITE: begin
                        if (wrIssue) begin
                            issueCnt <= issueCnt + CNT_ONE;
                            if (issueCnt + CNT_ONE == len) begin
                                state               <= RESP;
                                respValidQ[grantCh] <= 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (state == READ) begin
                // A byte issued just before the pause was never sampled: fetch it again.
                issueCnt <= recvCnt;
                pend     <= 1'b0;
            end
        end
    end
endmodule
